// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: FSM state encoding and PC stride.
package pc_sequencer_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int PC_INCR    = 4;

    typedef enum logic [2:0] {
        ST_RUN        = 3'd0,
        ST_IO_WAIT    = 3'd1,
        ST_IO_RELEASE = 3'd2,
        ST_IO_DRAIN   = 3'd3,
        ST_HALTED     = 3'd4
    } seq_state_e;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC select: jump beats branch beats sequential; seq_only forces PC+4.
module pc_next_mux
    import pc_sequencer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] pc_current,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              seq_only,
    output logic [ADDR_W-1:0] pc_next
);

    logic [ADDR_W-1:0] pc_seq;

    always_comb begin
        // Wraps naturally modulo 2^ADDR_W.
        pc_seq = pc_current + ADDR_W'(PC_INCR);
        if (seq_only)          pc_next = pc_seq;
        else if (jump)         pc_next = jump_target;
        else if (branch_taken) pc_next = branch_target;
        else                   pc_next = pc_seq;
    end

endmodule

// File: rtl/pc_sequencer.sv
// PC update control: next-PC select, I/O stall on a debounced insert handshake,
// post-release drain so one press completes one I/O instruction, sticky halt.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DEBOUNCE = 5,
    parameter int CNT_W    = 3
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_current,
    input  logic              input_flag,
    input  logic              output_flag,
    input  logic              insert,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              halt,
    output logic [ADDR_W-1:0] pc_next,
    output logic              pc_write,
    output logic              io_busy,
    output logic              io_done,
    output logic              halted
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             io_busy_q, io_busy_d;
    logic             io_done_q, io_done_d;
    logic             halted_q, halted_d;
    logic             pc_we, seq_only, io;

    assign io = input_flag | output_flag;

    pc_next_mux #(.ADDR_W(ADDR_W)) u_mux (
        .pc_current    (pc_current),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .seq_only      (seq_only),
        .pc_next       (pc_next)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        io_busy_d = io_busy_q;
        pc_we     = 1'b0;
        seq_only  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (halt) begin
                    state_d = ST_HALTED;
                end else if (io) begin
                    state_d   = ST_IO_WAIT;
                    cnt_d     = '0;
                    io_busy_d = 1'b1;
                end else begin
                    pc_we = 1'b1;
                end
            end
            ST_IO_WAIT: begin
                // Any low sample restarts the debounce count.
                if (!insert) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IO_RELEASE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_IO_RELEASE: begin
                pc_we     = 1'b1;
                seq_only  = 1'b1;
                io_busy_d = 1'b0;
                state_d   = ST_IO_DRAIN;
            end
            ST_IO_DRAIN: begin
                // Hold any new I/O instruction until the operator lets go.
                if (halt) begin
                    state_d = ST_HALTED;
                end else if (insert) begin
                    pc_we = !io;
                end else if (io) begin
                    state_d   = ST_IO_WAIT;
                    cnt_d     = '0;
                    io_busy_d = 1'b1;
                end else begin
                    pc_we   = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_HALTED: ;
            default: state_d = ST_RUN;
        endcase
        io_done_d = (state_q == ST_IO_RELEASE);
        halted_d  = (state_d == ST_HALTED);
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            io_busy_q <= 1'b0;
            io_done_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            io_busy_q <= io_busy_d;
            io_done_q <= io_done_d;
            halted_q  <= halted_d;
        end
    end

    assign pc_write = pc_we & reset;
    assign io_busy  = io_busy_q;
    assign io_done  = io_done_q;
    assign halted   = halted_q;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Controls updates of the MIPS program counter register.
- Each cycle it selects the next PC: sequential, branch or jump.
- Stalls the PC while an IN/OUT instruction waits for a debounced operator `insert` handshake.
- Handles a sticky halt.
- Sits between the decode/branch logic and the PC register, and drives that register's write enable and next-address input.

Parameters:
- ADDR_W, 32, PC/address width
- DEBOUNCE, 5, consecutive cycles `insert` must be high to complete an I/O instruction (≥1)
- CNT_W, 3, debounce counter width (must hold DEBOUNCE-1)

Ports:
- CLK  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- pc_current  in  ADDR_W  current PC register value
- input_flag  in  1  decoded instruction is IN
- output_flag  in  1  decoded instruction is OUT
- insert  in  1  operator/device acknowledge (already synchronised)
- branch_taken  in  1  branch resolved taken this cycle
- branch_target  in  ADDR_W  branch destination
- jump  in  1  unconditional jump this cycle
- jump_target  in  ADDR_W  jump destination
- halt  in  1  halt instruction decoded
- pc_next  out  ADDR_W  value to load into the PC
- pc_write  out  1  PC register load enable
- io_busy  out  1  high while stalled on I/O (registered)
- io_done  out  1  one-cycle pulse when an I/O instruction completes (registered)
- halted  out  1  processor halted (registered)

Behaviour:
- **Reset (reset=0, async):** state=RUN, debounce counter=0, io_busy=0, io_done=0, halted=0. pc_write=0 while reset is low.
- **States:** RUN, IO_WAIT, IO_RELEASE, IO_DRAIN, HALTED. io = input_flag|output_flag.
- **pc_next (combinational):** jump ? jump_target : branch_taken ? branch_target : pc_current+4.
  - The addition is modulo 2^ADDR_W; 0xFFFFFFFC wraps to 0x00000000.
  - In IO_RELEASE, pc_next = pc_current+4 regardless of jump/branch.
- **RUN:**
  - halt=1: pc_write=0, go HALTED. halt has priority over io.
  - else io=1: pc_write=0, go IO_WAIT, counter=0, io_busy<=1.
  - else pc_write=1.
- **IO_WAIT:**
  - pc_write=0.
  - insert=1 and counter==DEBOUNCE-1: go IO_RELEASE, counter=0.
  - insert=1 otherwise: counter+1.
  - insert=0: counter=0 (a glitch restarts the count).
  - Completion therefore requires DEBOUNCE consecutive high samples.
- **IO_RELEASE (exactly 1 cycle):**
  - pc_write=1, pc_next=pc_current+4.
  - io_busy<=0, io_done<=1 (visible the following cycle, for 1 cycle).
  - Go IO_DRAIN.
- **IO_DRAIN** (prevents one press completing two I/O instructions):
  - halt=1: go HALTED.
  - insert=1 and io=1: pc_write=0, stay.
  - insert=1 and io=0: pc_write=1, stay.
  - insert=0 and io=1: pc_write=0, go IO_WAIT, io_busy<=1.
  - insert=0 and io=0: pc_write=1, go RUN.
- **HALTED:** pc_write=0, halted=1. Exit only by reset.
- **Latency:**
  - Non-I/O instruction: pc_write asserted the same cycle (0 stall).
  - I/O instruction with insert already high and a clean drain: minimum 1+DEBOUNCE stall cycles before the IO_RELEASE write.
- **Mid-operation events:**
  - Reset in any state returns to RUN with the counter cleared; no io_done is produced.
  - halt while in IO_WAIT is ignored; the pending I/O instruction still owns decode.
- io_done and io_busy are never high in the same cycle.

Decomposition:
- Shared package (e.g. mips_pkg):
  - state encoding: RUN=0, IO_WAIT=1, IO_RELEASE=2, IO_DRAIN=3, HALTED=4, 3-bit
  - PC_INCR=4
  - ADDR_W default
- Sub-module `pc_next_mux`: combinational jump/branch/sequential priority select plus +4 adder. Keeps the FSM file purely sequential.

Test Plan:
- Reset: hold reset=0 with insert=1, io=1 → pc_write=0, io_busy=0, halted=0. Release reset, io=0, pc_current=0x100 → pc_write=1, pc_next=0x104.
- Priority: jump=1 (0x400), branch_taken=1 (0x200) → pc_next=0x400. jump=0 → 0x200. Both 0 with pc_current=0xFFFFFFFC → 0x00000000.
- I/O debounce: input_flag=1, pc_current=0x40; insert high cycles 1–3, low 1 cycle, then high 5 cycles → release only after the 5 consecutive highs: one pc_write, pc_next=0x44, io_done pulse next cycle.
- Drain: after release, hold insert=1 with the next instruction output_flag=1 → pc_write stays 0 and state stays IO_DRAIN. Drop insert → IO_WAIT, io_busy=1.
- Halt vs io: halt=1 and input_flag=1 same cycle in RUN → HALTED, halted=1, no io_busy. Any later stimulus → pc_write=0 until reset.
- Reset mid-wait: assert reset on the 3rd debounce cycle → async return to RUN, io_busy=0, no io_done. A new IN instruction needs the full 5 cycles.
